// File: rtl/pipe_hazard_if.sv
// Hazard-control signal bundle between the pipeline datapath (master) and
// the stall/flush scheduler (slave), plus scheduler state for observation.
interface pipe_hazard_if;
  logic       i_stall;
  logic       d_reqM;
  logic       d_data_okM;
  logic       div_startE;
  logic       mem_readE;
  logic [4:0] reg_writeE;
  logic [4:0] rsD;
  logic [4:0] rtD;
  logic       exceptM;
  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       stallM;
  logic       stallW;
  logic       flushD;
  logic       flushE;
  logic       flushM;
  logic       flushW;
  logic       div_busy;
  logic       exc_taken;
  logic       dmem_state_dbg;
  logic [1:0] div_state_dbg;

  modport master (
    output i_stall, d_reqM, d_data_okM, div_startE, mem_readE,
           reg_writeE, rsD, rtD, exceptM,
    input  stallF, stallD, stallE, stallM, stallW,
           flushD, flushE, flushM, flushW, div_busy, exc_taken,
           dmem_state_dbg, div_state_dbg
  );

  modport slave (
    input  i_stall, d_reqM, d_data_okM, div_startE, mem_readE,
           reg_writeE, rsD, rtD, exceptM,
    output stallF, stallD, stallE, stallM, stallW,
           flushD, flushE, flushM, flushW, div_busy, exc_taken,
           dmem_state_dbg, div_state_dbg
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline: arbitrates fetch,
// data-memory, divider and load-use stalls against exception flushes.
module pipe_hazard_ctrl #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input logic         clk,
  input logic         rst,
  pipe_hazard_if.slave hz
);
  localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic {DM_IDLE, DM_WAIT} dmem_state_e;
  typedef enum logic [1:0] {DV_IDLE, DV_RUN, DV_DONE} div_state_e;

  dmem_state_e    dm_q, dm_d;
  div_state_e     dv_q, dv_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic mem_stall, div_stall, load_use, exc;
  logic stall_f, stall_d, stall_e, stall_m, stall_w;
  logic flush_d, flush_e, flush_m, flush_w, exc_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      dm_q  <= DM_IDLE;
      dv_q  <= DV_IDLE;
      cnt_q <= '0;
    end else begin
      dm_q  <= dm_d;
      dv_q  <= dv_d;
      cnt_q <= cnt_d;
    end
  end

  // An exception cannot abort an in-flight bus transaction, so it waits for
  // the completion pulse before redirecting.
  always_comb begin
    mem_stall = (dm_q == DM_WAIT) ? ~hz.d_data_okM : (hz.d_reqM & ~hz.d_data_okM);
    div_stall = ((dv_q == DV_IDLE) & hz.div_startE) | (dv_q == DV_RUN);
    load_use  = hz.mem_readE & (hz.reg_writeE != 5'd0) &
                ((hz.reg_writeE == hz.rsD) | (hz.reg_writeE == hz.rtD));
    exc       = hz.exceptM & ~((dm_q == DM_WAIT) & ~hz.d_data_okM);
  end

  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    stall_w   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_m   = 1'b0;
    flush_w   = 1'b0;
    exc_taken = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
      flush_w = 1'b1;
    end else if (exc) begin
      flush_d   = 1'b1;
      flush_e   = 1'b1;
      flush_m   = 1'b1;
      flush_w   = 1'b1;
      exc_taken = 1'b1;
    end else if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      stall_w = 1'b1;
    end else if (div_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else if (hz.i_stall) begin
      stall_f = 1'b1;
      flush_d = 1'b1;
    end
  end

  always_comb begin
    dm_d = dm_q;
    case (dm_q)
      DM_IDLE: if (hz.d_reqM & ~hz.d_data_okM) dm_d = DM_WAIT;
      DM_WAIT: if (hz.d_data_okM) dm_d = DM_IDLE;
      default: dm_d = DM_IDLE;
    endcase
  end

  // DONE parks the divider until E actually advances, so a divide still held
  // by a memory stall is not restarted.
  always_comb begin
    dv_d  = dv_q;
    cnt_d = cnt_q;
    if (flush_e) begin
      dv_d = DV_IDLE;
    end else begin
      case (dv_q)
        DV_IDLE: if (hz.div_startE) begin
          dv_d  = DV_RUN;
          cnt_d = CW'(DIV_CYCLES - 2);
        end
        DV_RUN: begin
          if (cnt_q == '0) dv_d = DV_DONE;
          else cnt_d = cnt_q - 1'b1;
        end
        DV_DONE: if (~stall_e) dv_d = DV_IDLE;
        default: dv_d = DV_IDLE;
      endcase
    end
  end

  assign hz.stallF         = stall_f;
  assign hz.stallD         = stall_d;
  assign hz.stallE         = stall_e;
  assign hz.stallM         = stall_m;
  assign hz.stallW         = stall_w;
  assign hz.flushD         = flush_d;
  assign hz.flushE         = flush_e;
  assign hz.flushM         = flush_m;
  assign hz.flushW         = flush_w;
  assign hz.exc_taken      = exc_taken;
  assign hz.div_busy       = ~rst & (dv_q == DV_RUN);
  assign hz.dmem_state_dbg = dm_q;
  assign hz.div_state_dbg  = dv_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, directed multi-cycle sequences,
// then random stimulus against a cycle-count reference model.
module tb_pipe_hazard_ctrl;
  localparam int DIVC = 4;

  // {stallF,stallD,stallE,stallM,stallW,flushD,flushE,flushM,flushW,exc_taken,div_busy}
  localparam logic [10:0] O_NONE = 11'b00000_0000_0_0;
  localparam logic [10:0] O_RST  = 11'b00000_1111_0_0;
  localparam logic [10:0] O_EXC  = 11'b00000_1111_1_0;
  localparam logic [10:0] O_MEM  = 11'b11111_0000_0_0;
  localparam logic [10:0] O_DIV  = 11'b11100_0010_0_0;
  localparam logic [10:0] O_LU   = 11'b11000_0100_0_0;
  localparam logic [10:0] O_IS   = 11'b10000_1000_0_0;
  localparam logic [10:0] BUSY   = 11'b00000_0000_0_1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  pipe_hazard_if hz();

  pipe_hazard_ctrl #(.DIV_CYCLES(DIVC)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic clear_in();
    hz.i_stall    = 1'b0;
    hz.d_reqM     = 1'b0;
    hz.d_data_okM = 1'b0;
    hz.div_startE = 1'b0;
    hz.mem_readE  = 1'b0;
    hz.reg_writeE = 5'd0;
    hz.rsD        = 5'd0;
    hz.rtD        = 5'd0;
    hz.exceptM    = 1'b0;
  endtask

  function automatic logic [10:0] get_out();
    return {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW,
            hz.flushD, hz.flushE, hz.flushM, hz.flushW, hz.exc_taken, hz.div_busy};
  endfunction

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%b expected=%b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Inputs are driven at the falling edge; outputs are checked 1 ns later.
  task automatic tick(input string name, input logic [10:0] exp);
    #1;
    check(name, get_out(), exp);
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        i_stall;
    logic        d_reqM;
    logic        d_data_okM;
    logic        mem_readE;
    logic        exceptM;
    logic [4:0]  rw;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic is, input logic rq, input logic ok,
                              input logic mr, input logic ex, input logic [4:0] rw,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [10:0] exp);
    vec_t v;
    v.i_stall = is; v.d_reqM = rq; v.d_data_okM = ok; v.mem_readE = mr;
    v.exceptM = ex; v.rw = rw; v.rs = rs; v.rt = rt; v.exp = exp;
    return v;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  logic [10:0] exp_q[$];
  bit m_wait;
  bit m_div_active;
  bit m_div_done;
  int m_div_cnt;

  task automatic model_reset();
    m_wait = 0; m_div_active = 0; m_div_done = 0; m_div_cnt = 0;
  endtask

  // Divider tracked as "stall cycles delivered so far"; finished after DIVC.
  task automatic model_step();
    bit mem_s, div_s, lu, ex;
    logic [10:0] o;
    mem_s = m_wait ? !hz.d_data_okM : (hz.d_reqM && !hz.d_data_okM);
    div_s = m_div_active || (!m_div_done && hz.div_startE);
    lu    = hz.mem_readE && hz.reg_writeE != 0 &&
            (hz.reg_writeE == hz.rsD || hz.reg_writeE == hz.rtD);
    ex    = hz.exceptM && !(m_wait && !hz.d_data_okM);
    if (ex)              o = O_EXC;
    else if (mem_s)      o = O_MEM;
    else if (div_s)      o = O_DIV;
    else if (lu)         o = O_LU;
    else if (hz.i_stall) o = O_IS;
    else                 o = O_NONE;
    o[0] = m_div_active;
    exp_q.push_back(o);
    if (m_wait) m_wait = !hz.d_data_okM;
    else        m_wait = hz.d_reqM && !hz.d_data_okM;
    if (o[4]) begin
      m_div_active = 0; m_div_done = 0; m_div_cnt = 0;
    end else if (div_s) begin
      m_div_cnt++;
      if (m_div_cnt >= DIVC) begin
        m_div_active = 0; m_div_done = 1; m_div_cnt = 0;
      end else begin
        m_div_active = 1;
      end
    end else if (m_div_done && !o[8]) begin
      m_div_done = 0;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_checks = 0;
    n_err    = 0;
    clear_in();
    rst = 1'b1;
    hz.i_stall    = 1'b1;
    hz.div_startE = 1'b1;
    @(negedge clk);

    // reset overrides live inputs
    tick("rst_cyc0", O_RST);
    tick("rst_cyc1", O_RST);
    rst = 1'b0;
    clear_in();
    tick("rst_release", O_NONE);

    // single-cycle vectors from the idle state
    vecs.push_back(mk(0, 0, 0, 1, 0, 5'd5, 5'd5, 5'd0, O_LU));
    vecs.push_back(mk(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, O_NONE));
    vecs.push_back(mk(0, 0, 0, 1, 0, 5'd7, 5'd1, 5'd7, O_LU));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5, O_NONE));
    vecs.push_back(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, O_IS));
    vecs.push_back(mk(1, 0, 0, 1, 0, 5'd3, 5'd2, 5'd3, O_LU));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, O_NONE));
    vecs.push_back(mk(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, O_IS));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, O_EXC));
    vecs.push_back(mk(1, 0, 0, 1, 1, 5'd4, 5'd4, 5'd0, O_EXC));
    vecs.push_back(mk(0, 1, 1, 0, 1, 5'd0, 5'd0, 5'd0, O_EXC));
    vecs.push_back(mk(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, O_NONE));
    for (int i = 0; i < vecs.size(); i++) begin
      clear_in();
      hz.i_stall = vecs[i].i_stall;  hz.d_reqM = vecs[i].d_reqM;
      hz.d_data_okM = vecs[i].d_data_okM; hz.mem_readE = vecs[i].mem_readE;
      hz.exceptM = vecs[i].exceptM;  hz.reg_writeE = vecs[i].rw;
      hz.rsD = vecs[i].rs;           hz.rtD = vecs[i].rt;
      tick($sformatf("vec%0d", i), vecs[i].exp);
    end
    clear_in();

    // data memory wait: stall two cycles, released on the completion pulse
    hz.d_reqM = 1'b1;
    tick("dmem_c1", O_MEM);
    tick("dmem_c2", O_MEM);
    hz.d_data_okM = 1'b1;
    tick("dmem_c3", O_NONE);
    clear_in();
    tick("dmem_idle", O_NONE);

    // divide: DIVC stall cycles, busy for DIVC-1, then E advances
    hz.div_startE = 1'b1;
    tick("div_c1", O_DIV);
    for (int i = 2; i <= DIVC; i++) tick($sformatf("div_c%0d", i), O_DIV | BUSY);
    tick("div_done", O_NONE);
    hz.div_startE = 1'b0;
    tick("div_idle", O_NONE);

    // divide finishing while a memory stall holds E must not restart
    hz.div_startE = 1'b1;
    tick("divm_c1", O_DIV);
    for (int i = 2; i <= DIVC; i++) tick($sformatf("divm_c%0d", i), O_DIV | BUSY);
    hz.d_reqM = 1'b1;
    tick("divm_memhold", O_MEM);
    hz.d_data_okM = 1'b1;
    tick("divm_norestart", O_NONE);
    clear_in();
    tick("divm_idle", O_NONE);

    // exception deferred behind an outstanding bus transaction
    hz.d_reqM = 1'b1;
    tick("excw_req", O_MEM);
    hz.exceptM = 1'b1;
    tick("excw_defer1", O_MEM);
    tick("excw_defer2", O_MEM);
    hz.d_data_okM = 1'b1;
    tick("excw_taken", O_EXC);
    clear_in();
    tick("excw_after", O_NONE);

    // exception aborts a running divide
    hz.div_startE = 1'b1;
    tick("excd_start", O_DIV);
    tick("excd_run", O_DIV | BUSY);
    hz.div_startE = 1'b0;
    hz.exceptM    = 1'b1;
    tick("excd_flush", O_EXC | BUSY);
    clear_in();
    tick("excd_idle", O_NONE);
    hz.div_startE = 1'b1;
    tick("excd_restart", O_DIV);

    // random stimulus against the reference model
    clear_in();
    rst = 1'b1;
    tick("rnd_rst", O_RST);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      hz.i_stall    = ($urandom_range(99) < 30);
      hz.d_reqM     = ($urandom_range(99) < 30);
      hz.d_data_okM = ($urandom_range(99) < (m_wait ? 40 : 15));
      hz.div_startE = ($urandom_range(99) < 25);
      hz.mem_readE  = ($urandom_range(99) < 50);
      hz.reg_writeE = 5'($urandom_range(3));
      hz.rsD        = 5'($urandom_range(3));
      hz.rtD        = 5'($urandom_range(3));
      hz.exceptM    = ($urandom_range(99) < 8);
      #1;
      model_step();
      check($sformatf("rnd%0d", c), get_out(), exp_q.pop_front());
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // safety net in case the sequence stalls
  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: got=no completion expected=completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage MIPS pipeline (F/D/E/M/W).
- Drives the stall*/flush* inputs of every stage register, including the MEM/WB register's stallW/flushW.
- Arbitrates four stall sources (instruction fetch wait, data memory wait, multi-cycle divider, load-use) and exception flush.
- Tracks the data-memory handshake and divider occupancy with small internal FSMs.

Parameters:
DIV_CYCLES, 32, total cycles a divide instruction holds the E stage (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
i_stall  in  1  instruction fetch not ready this cycle
d_reqM  in  1  load/store in M issuing a data request
d_data_okM  in  1  data bus completion (1-cycle pulse)
div_startE  in  1  divide instruction present in E
mem_readE  in  1  instruction in E is a load
reg_writeE  in  5  destination register of instruction in E
rsD  in  5  rs of instruction in D
rtD  in  5  rt of instruction in D
exceptM  in  1  instruction in M raised an exception
stallF  out  1  hold PC / F
stallD  out  1  hold F/D register
stallE  out  1  hold D/E register
stallM  out  1  hold E/M register
stallW  out  1  hold M/W register
flushD  out  1  bubble into D
flushE  out  1  bubble into E
flushM  out  1  bubble into M
flushW  out  1  bubble into W
div_busy  out  1  divider FSM in RUN
exc_taken  out  1  exception accepted this cycle (PC redirect)

Behaviour:
- Outputs are combinational from inputs and registered state.
- Reset: dmem FSM=IDLE, div FSM=IDLE, counter=0. During rst all stall*=0, all flush*=1, exc_taken=0, div_busy=0.
- Dmem FSM, IDLE/WAIT:
  - IDLE with d_reqM & ~d_data_okM -> WAIT.
  - WAIT with d_data_okM -> IDLE.
  - mem_stall = d_reqM & ~d_data_okM in IDLE, or ~d_data_okM in WAIT.
  - Same-cycle d_reqM & d_data_okM: no stall, stay IDLE.
- Div FSM, IDLE/RUN/DONE:
  - IDLE & div_startE -> RUN, counter <= DIV_CYCLES-2.
  - RUN: decrement counter; at 0 -> DONE.
  - DONE -> IDLE when ~stallE or flushE.
  - div_stall = (IDLE & div_startE) | RUN. This gives exactly DIV_CYCLES stall cycles.
  - DONE blocks a restart while E is held by another source.
  - flushE in any state -> IDLE (abort).
- load_use = mem_readE & (reg_writeE!=0) & (reg_writeE==rsD | reg_writeE==rtD).
- Priority, highest first:
  1. Exception: exc = exceptM & ~(dmem WAIT & ~d_data_okM). An exception during an outstanding bus transaction is deferred until the cycle of d_data_okM (AXI cannot abort). When exc: flushD=flushE=flushM=flushW=1, all stall*=0, exc_taken=1.
  2. mem_stall: stallF..stallW=1, no flush.
  3. div_stall: stallF=stallD=stallE=1, flushM=1.
  4. load_use: stallF=stallD=1, flushE=1.
  5. i_stall: stallF=1, flushD=1.
  6. Otherwise all 0.
- Lower-priority sources are masked, not lost. They re-evaluate next cycle from the held state.
- A flush is never asserted on a stage whose own stall is asserted.

Test Plan:
- Reset held 2 cycles, then released with all inputs 0 -> during rst flushD..flushW=1; after release all outputs 0, div_busy=0.
- d_reqM=1 for 3 cycles, d_data_okM pulses on cycle 3 -> stallF..stallW=1 on cycles 1-2, 0 on cycle 3; FSM back to IDLE.
- div_startE held, DIV_CYCLES=4 -> stallE=1 for exactly 4 cycles, flushM=1 same cycles, div_busy=1 for 3, then 0.
- mem_readE=1, reg_writeE=5, rsD=5 -> stallF=stallD=1, flushE=1 one cycle; reg_writeE=0, rsD=0 -> no stall.
- exceptM=1 while dmem WAIT, d_data_okM 2 cycles later -> exc_taken=0 until d_data_ok cycle, then exc_taken=1 with flushD..flushW=1.
- Divide in RUN plus exceptM=1 (dmem IDLE) -> flushE=1, div FSM IDLE next cycle, div_busy=0.
